// File: rtl/ram4k_fill_engine.sv
// ram4k_fill_engine
//   Fills a window of a single-port RAM with a constant or incrementing
//   pattern, then optionally reads the window back and compares it.
//   Addresses wrap modulo 2^ADDR_W, so a full-size count touches every word
//   exactly once.
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for start; outputs hold, error/err_addr retained
//   S_FILL   | one RAM write per cycle, count cycles
//   S_VERIFY | one RAM read/compare per cycle, stops on first mismatch
//   S_DONE   | done pulse for one cycle, then back to S_IDLE
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               begin an operation (only honoured in S_IDLE)
//   base, count         first word address and number of words (0..2^ADDR_W)
//   mode, seed          0: constant seed, 1: seed + index
//   verify_en           run a read-back pass after the fill
//   ram_out             RAM read data (combinational from ram_address)
//   ram_in, ram_address RAM write data and address
//   ram_load            RAM write enable
//   busy, done          operation in progress / one-cycle completion pulse
//   error, err_addr     first verify mismatch and its address
module ram4k_fill_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              verify_en,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic              mode_q;
  logic [DATA_W-1:0] seed_q;
  logic              verify_q;
  logic [ADDR_W:0]   remain_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] pat_q;
  logic              load_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic [DATA_W-1:0] pat_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]   remain_d;
  logic              last;

  // pat_q always holds pattern(i) for the word currently on the bus; it is
  // both the write data in S_FILL and the compare value in S_VERIFY.
  always_comb begin
    pat_d    = pat_q + {{(DATA_W-1){1'b0}}, mode_q};
    addr_d   = addr_q + ADDR_ONE;
    remain_d = remain_q - CNT_ONE;
    last     = (remain_q == CNT_ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      mode_q     <= 1'b0;
      seed_q     <= '0;
      verify_q   <= 1'b0;
      remain_q   <= '0;
      addr_q     <= '0;
      pat_q      <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q     <= base;
            count_q    <= count;
            mode_q     <= mode;
            seed_q     <= seed;
            verify_q   <= verify_en;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            addr_q     <= base;
            pat_q      <= seed;
            remain_q   <= count;
            if (count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FILL;
              load_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (last) begin
            // Rewind the sweep so a verify pass starts at base with seed.
            load_q   <= 1'b0;
            addr_q   <= base_q;
            pat_q    <= seed_q;
            remain_q <= count_q;
            if (verify_q) begin
              state_q <= S_VERIFY;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            addr_q   <= addr_d;
            pat_q    <= pat_d;
            remain_q <= remain_d;
          end
        end
        S_VERIFY: begin
          if (ram_out != pat_q) begin
            error_q    <= 1'b1;
            err_addr_q <= addr_q;
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            addr_q   <= addr_d;
            pat_q    <= pat_d;
            remain_q <= remain_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_in      = pat_q;
  assign ram_address = addr_q;
  assign ram_load    = load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_addr    = err_addr_q;

endmodule
